// File: rtl/keypad_matrix_emulator.sv
// Responder side of a 4x4 row-sweep/column-sense membrane keypad: replays one
// requested key press with contact bounce, a stable hold and a release gap.
module keypad_matrix_emulator #(
    parameter int          BOUNCE_CYCLES = 16,
    parameter int          HOLD_CYCLES   = 1000,
    parameter int          GAP_CYCLES    = 1000,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_sweep,
    input  logic [3:0] key_code,
    input  logic       press_req,
    output logic [3:0] column_out,
    output logic       busy,
    output logic       done,
    output logic       contact
);

    localparam logic [15:0] BOUNCE_LD = 16'(BOUNCE_CYCLES - 1);
    localparam logic [15:0] HOLD_LD   = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] GAP_LD    = 16'(GAP_CYCLES - 1);
    localparam bit          NO_BOUNCE = (BOUNCE_CYCLES == 0);

    typedef enum logic [2:0] {
        IDLE,
        BOUNCE_PRESS,
        HOLD,
        BOUNCE_RELEASE,
        GAP
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [3:0]  key_q;
    logic [7:0]  lfsr;
    logic        lfsr_fb;

    // x^8 + x^6 + x^5 + x^4 + 1, shifted left with feedback into bit 0
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    // contact is registered together with the state so it always matches the
    // phase the state machine is currently in
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            key_q   <= '0;
            lfsr    <= LFSR_SEED;
            contact <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (press_req) begin
                        key_q <= key_code;
                        busy  <= 1'b1;
                        if (NO_BOUNCE) begin
                            state   <= HOLD;
                            cnt     <= HOLD_LD;
                            contact <= 1'b1;
                        end else begin
                            state   <= BOUNCE_PRESS;
                            cnt     <= BOUNCE_LD;
                            contact <= lfsr[0];
                        end
                    end
                end
                BOUNCE_PRESS: begin
                    if (cnt == '0) begin
                        state   <= HOLD;
                        cnt     <= HOLD_LD;
                        contact <= 1'b1;
                    end else begin
                        cnt     <= cnt - 16'd1;
                        contact <= lfsr[0];
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        if (NO_BOUNCE) begin
                            state   <= GAP;
                            cnt     <= GAP_LD;
                            contact <= 1'b0;
                        end else begin
                            state   <= BOUNCE_RELEASE;
                            cnt     <= BOUNCE_LD;
                            contact <= lfsr[0];
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                BOUNCE_RELEASE: begin
                    if (cnt == '0) begin
                        state   <= GAP;
                        cnt     <= GAP_LD;
                        contact <= 1'b0;
                    end else begin
                        cnt     <= cnt - 16'd1;
                        contact <= lfsr[0];
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    contact <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Wire path through the switch: only the latched key's row and column matter
    always_comb begin
        column_out = 4'b1111;
        if (contact && !row_sweep[key_q[3:2]])
            column_out[key_q[1:0]] = 1'b0;
    end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Scoreboard bench for keypad_matrix_emulator: stimulus queues per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_keypad_matrix_emulator;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_sweep;
    logic [3:0] key_code;
    logic       press_req;
    logic [3:0] column_out;
    logic       busy;
    logic       done;
    logic       contact;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [3:0] col;
        logic       busy;
        logic       done;
        logic       contact;
    } exp_t;

    exp_t exp_q[$];
    int   exp_id = 0;

    keypad_matrix_emulator #(
        .BOUNCE_CYCLES(4),
        .HOLD_CYCLES  (8),
        .GAP_CYCLES   (6),
        .LFSR_SEED    (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_sweep (row_sweep),
        .key_code  (key_code),
        .press_req (press_req),
        .column_out(column_out),
        .busy      (busy),
        .done      (done),
        .contact   (contact)
    );

    always #5 clk = ~clk;

    // Reference bounce source: free-running LFSR, lbit is the bit seen at the last edge
    logic [7:0] lm;
    logic       lbit;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            lm   <= 8'hA5;
            lbit <= 1'b0;
        end else begin
            lbit <= lm[0];
            lm   <= {lm[6:0], lm[7] ^ lm[5] ^ lm[4] ^ lm[3]};
        end
    end

    // Minimal scanner model: decodes the low row and low column into a key code
    logic [3:0] scan_code;
    logic       scan_pressed;
    int         scan_miss;
    function automatic logic [1:0] low_idx(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int k = 3; k >= 0; k--) if (!v[k]) r = 2'(k);
        return r;
    endfunction
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            scan_code    <= 4'h0;
            scan_pressed <= 1'b0;
            scan_miss    <= 0;
        end else if (column_out != 4'b1111) begin
            scan_code    <= {low_idx(row_sweep), low_idx(column_out)};
            scan_pressed <= 1'b1;
            scan_miss    <= 0;
        end else begin
            if (scan_miss < 7) scan_miss <= scan_miss + 1;
            if (scan_miss >= 3) scan_pressed <= 1'b0;
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            exp_id++;
            n_checks++;
            if ({column_out, busy, done, contact} === e) n_pass++;
            else $display("FAIL cycle_chk #%0d: got col=%b busy=%b done=%b contact=%b, want col=%b busy=%b done=%b contact=%b",
                          exp_id, column_out, busy, done, contact, e.col, e.busy, e.done, e.contact);
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, want);
    endtask

    task automatic push(input logic [3:0] col, input logic b, input logic d, input logic c);
        exp_t e;
        e.col = col; e.busy = b; e.done = d; e.contact = c;
        exp_q.push_back(e);
    endtask

    logic [3:0] rot_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // hit_rows/hit_col: hand-derived row pattern that selects the key's row and
    // the column_out value it produces while contact is closed
    task automatic run_press(input logic [3:0] key, input logic [3:0] rows,
                             input logic [3:0] hit_rows, input logic [3:0] hit_col,
                             input int rot, input int dup_at, input int abort_at);
        logic       c_e;
        logic [3:0] col_e;
        key_code  = key;
        row_sweep = rows;
        press_req = 1'b1;
        @(posedge clk); #1;
        press_req = 1'b0;
        for (int i = 0; i < 22; i++) begin
            if (rot == 2 || (rot == 1 && i >= 4 && i < 12)) row_sweep = rot_tab[i % 4];
            if (i == dup_at) begin press_req = 1'b1; key_code = 4'hF; end
            if (i == dup_at + 1) begin press_req = 1'b0; key_code = key; end
            if (rot == 2 && i == 11) begin
                chk("scan_pressed_hold", {7'd0, scan_pressed}, 8'h01);
                chk("scan_code_hold", {4'd0, scan_code}, {4'd0, key});
            end
            if (i == abort_at) begin
                #2 rst = 1'b0;
                push(4'b1111, 1'b0, 1'b0, 1'b0);
                @(posedge clk); #1;
                push(4'b1111, 1'b0, 1'b0, 1'b0);
                rst = 1'b1;
                return;
            end
            c_e   = (i < 4 || (i >= 12 && i < 16)) ? lbit : (i < 12);
            col_e = (c_e && row_sweep == hit_rows) ? hit_col : 4'b1111;
            push(col_e, 1'b1, 1'b0, c_e);
            @(posedge clk); #1;
        end
        push(4'b1111, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        push(4'b1111, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        press_req = 1'b1;
        row_sweep = 4'b1110;
        key_code  = 4'h6;
        @(posedge clk); #1;
        push(4'b1111, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        push(4'b1111, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk); #1;

        // basic press of key 6 (row1,col2) with row1 held low
        run_press(4'h6, 4'b1101, 4'b1101, 4'b1011, 0, -1, -1);
        // rows rotating during HOLD
        run_press(4'h6, 4'b1101, 4'b1101, 4'b1011, 1, -1, -1);
        // second request while busy is ignored
        run_press(4'h6, 4'b1101, 4'b1101, 4'b1011, 0, 10, -1);
        // reset in the middle of HOLD, then a full sequence
        run_press(4'h6, 4'b1101, 4'b1101, 4'b1011, 0, -1, 7);
        for (int k = 0; k < 3; k++) begin
            push(4'b1111, 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        run_press(4'h6, 4'b1101, 4'b1101, 4'b1011, 0, -1, -1);
        // loopback: key 9 (row2,col1) under a continuously sweeping scanner
        run_press(4'h9, 4'b1110, 4'b1011, 4'b1101, 2, -1, -1);
        chk("scan_released", {7'd0, scan_pressed}, 8'h00);
        chk("scan_code_final", {4'd0, scan_code}, 8'h09);

        @(negedge clk); #1;
        chk("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
